// File: rtl/core_bus_interface_if.sv
// Bundle of request-side and bus-side signals for core_bus_interface.
// slave  : the view taken by core_bus_interface itself.
// master : the view taken by the surrounding control path / bus model.
interface core_bus_interface_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rd;
    logic              bus_wr;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic [DATA_W-1:0] bus_datain;
    logic              bus_fromin;
    logic              busy;
    logic              err;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, bus_ack, bus_rdata,
        output req_ready, bus_addr, bus_wdata, bus_rd, bus_wr,
               bus_datain, bus_fromin, busy, err
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, bus_ack, bus_rdata,
        input  req_ready, bus_addr, bus_wdata, bus_rd, bus_wr,
               bus_datain, bus_fromin, busy, err
    );
endinterface

// File: rtl/core_bus_interface.sv
// Single-outstanding load/store unit driving a strobe/ack external bus.
// Loads deliver the read word on bus_datain with a one-cycle bus_fromin pulse.
// Optional ack timeout: define CORE_BUS_TIMEOUT_EN to enable the REQ wait
// limit of TIMEOUT_CYCLES cycles; otherwise REQ waits forever and err is 0.
module core_bus_interface #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    core_bus_interface_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state;
    logic   write_q;

    if (TIMEOUT_CYCLES < 1 || ADDR_W < 1 || DATA_W < 1) begin : g_param_check
        $error("core_bus_interface: ADDR_W, DATA_W and TIMEOUT_CYCLES must be >= 1");
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);

`ifdef CORE_BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;
    logic             tmo_hit;

    // Last REQ cycle allowed before the limit is reached.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // Transaction FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            write_q        <= 1'b0;
            bus.bus_addr   <= '0;
            bus.bus_wdata  <= '0;
            bus.bus_datain <= '0;
            bus.bus_rd     <= 1'b0;
            bus.bus_wr     <= 1'b0;
            bus.bus_fromin <= 1'b0;
`ifdef CORE_BUS_TIMEOUT_EN
            tmo_cnt        <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            bus.bus_fromin <= 1'b0;
`ifdef CORE_BUS_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.bus_addr  <= bus.req_addr;
                        bus.bus_wdata <= bus.req_wdata;
                        write_q       <= bus.req_write;
                        bus.bus_rd    <= ~bus.req_write;
                        bus.bus_wr    <= bus.req_write;
                        state         <= REQ;
`ifdef CORE_BUS_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        bus.bus_rd <= 1'b0;
                        bus.bus_wr <= 1'b0;
                        if (!write_q) begin
                            bus.bus_datain <= bus.bus_rdata;
                            bus.bus_fromin <= 1'b1;
                            state          <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
`ifdef CORE_BUS_TIMEOUT_EN
                    // Ack takes priority; the timeout only fires on an ack-less edge.
                    else if (tmo_hit) begin
                        bus.bus_rd <= 1'b0;
                        bus.bus_wr <= 1'b0;
                        err_q      <= 1'b1;
                        if (!write_q) begin
                            bus.bus_datain <= '1;
                            bus.bus_fromin <= 1'b1;
                            state          <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus_interface.sv
// Scoreboard bench for core_bus_interface: the driver pushes expected bus
// transactions, load words and error pulses; a monitor pops and compares
// whenever the DUT raises a strobe, bus_fromin or err.
module tb_core_bus_interface;

`ifdef CORE_BUS_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          len;     // expected strobe cycles, 0 = not checked
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    core_bus_interface_if #(.ADDR_W(16), .DATA_W(16)) bus_if ();

    core_bus_interface #(
        .ADDR_W(16),
        .DATA_W(16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    txn_t        q_txn[$];
    logic [15:0] q_load[$];
    int          q_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic flag(input string name);
        n_total++;
        $display("FAIL %s: event seen with nothing expected at %0t", name, $time);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        bit   active = 0;
        int   cnt    = 0;
        txn_t cur;
        cur = '{write: 1'b0, addr: 16'h0, wdata: 16'h0, len: 0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                active = 0;
                continue;
            end
            if (bus_if.bus_rd || bus_if.bus_wr) begin
                if (!active) begin
                    if (q_txn.size() == 0) begin
                        flag("unexpected_strobe");
                    end else begin
                        cur    = q_txn.pop_front();
                        active = 1;
                        cnt    = 1;
                        chk("strobe_rd", {31'b0, bus_if.bus_rd}, {31'b0, ~cur.write});
                        chk("strobe_wr", {31'b0, bus_if.bus_wr}, {31'b0, cur.write});
                    end
                end else begin
                    cnt++;
                end
                if (active) begin
                    chk("bus_addr", {16'b0, bus_if.bus_addr}, {16'b0, cur.addr});
                    chk("bus_wdata", {16'b0, bus_if.bus_wdata}, {16'b0, cur.wdata});
                end
            end else if (active) begin
                active = 0;
                if (cur.len != 0) chk("strobe_len", cnt, cur.len);
            end
            if (bus_if.bus_fromin) begin
                if (q_load.size() == 0) flag("unexpected_fromin");
                else chk("load_data", {16'b0, bus_if.bus_datain}, {16'b0, q_load.pop_front()});
            end
            if (bus_if.err) begin
                if (q_err.size() == 0) flag("unexpected_err");
                else chk("err_pulse", {31'b0, bus_if.err}, q_err.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_txn(input logic w, input logic [15:0] a, input logic [15:0] d, input int len);
        txn_t t;
        t.write = w;
        t.addr  = a;
        t.wdata = d;
        t.len   = len;
        q_txn.push_back(t);
    endtask

    // Present a request at the current negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = w;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
    endtask

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = 16'h0;
        bus_if.req_wdata = 16'h0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rd", {31'b0, bus_if.bus_rd}, 0);
        chk("rst_busy", {31'b0, bus_if.busy}, 0);
        chk("rst_datain", {16'b0, bus_if.bus_datain}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, bus_if.req_ready}, 1);

        // Load 0x1234, ack in first REQ cycle
        push_txn(1'b0, 16'h1234, 16'h0000, 1);
        q_load.push_back(16'hBEEF);
        issue(1'b0, 16'h1234, 16'h0000);
        chk("ld_rd_T1", {31'b0, bus_if.bus_rd}, 1);
        chk("ld_busy_T1", {31'b0, bus_if.busy}, 1);
        chk("ld_ready_T1", {31'b0, bus_if.req_ready}, 0);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'hBEEF;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("ld_fromin_T2", {31'b0, bus_if.bus_fromin}, 1);
        chk("ld_rd_T2", {31'b0, bus_if.bus_rd}, 0);
        chk("ld_ready_T2", {31'b0, bus_if.req_ready}, 0);
        @(negedge clk);
        chk("ld_ready_T3", {31'b0, bus_if.req_ready}, 1);
        chk("ld_fromin_T3", {31'b0, bus_if.bus_fromin}, 0);

        // Store 0x0040 <- 0x00A5, ack after 3 wait cycles
        push_txn(1'b1, 16'h0040, 16'h00A5, 4);
        issue(1'b1, 16'h0040, 16'h00A5);
        chk("st_wr_T1", {31'b0, bus_if.bus_wr}, 1);
        chk("st_rd_T1", {31'b0, bus_if.bus_rd}, 0);
        repeat (3) @(negedge clk);
        bus_if.bus_ack = 1'b1;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("st_ready", {31'b0, bus_if.req_ready}, 1);
        chk("st_wr_low", {31'b0, bus_if.bus_wr}, 0);
        chk("st_datain_kept", {16'b0, bus_if.bus_datain}, 32'h0000BEEF);

        // Stray ack in IDLE, then held req_valid with a changed request during REQ
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'h1111;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("stray_ready", {31'b0, bus_if.req_ready}, 1);
        chk("stray_busy", {31'b0, bus_if.busy}, 0);
        chk("stray_datain", {16'b0, bus_if.bus_datain}, 32'h0000BEEF);
        push_txn(1'b0, 16'h0100, 16'h2222, 3);
        push_txn(1'b0, 16'h0200, 16'h3333, 1);
        q_load.push_back(16'h5A5A);
        q_load.push_back(16'h0F0F);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = 16'h0100;
        bus_if.req_wdata = 16'h2222;
        @(negedge clk);
        bus_if.req_addr  = 16'h0200;
        bus_if.req_wdata = 16'h3333;
        @(negedge clk);
        chk("hold_addr", {16'b0, bus_if.bus_addr}, 32'h00000100);
        @(negedge clk);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'h5A5A;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("b2b_done_ready", {31'b0, bus_if.req_ready}, 0);
        @(negedge clk);
        chk("b2b_idle_ready", {31'b0, bus_if.req_ready}, 1);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        chk("b2b_second_addr", {16'b0, bus_if.bus_addr}, 32'h00000200);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'h0F0F;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk("b2b_end_ready", {31'b0, bus_if.req_ready}, 1);

        // Asynchronous reset in the middle of a load
        push_txn(1'b0, 16'h7777, 16'h4444, 0);
        issue(1'b0, 16'h7777, 16'h4444);
        chk("arst_rd_before", {31'b0, bus_if.bus_rd}, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_rd", {31'b0, bus_if.bus_rd}, 0);
        chk("arst_wr", {31'b0, bus_if.bus_wr}, 0);
        chk("arst_addr", {16'b0, bus_if.bus_addr}, 0);
        chk("arst_wdata", {16'b0, bus_if.bus_wdata}, 0);
        chk("arst_datain", {16'b0, bus_if.bus_datain}, 0);
        chk("arst_busy", {31'b0, bus_if.busy}, 0);
        chk("arst_fromin", {31'b0, bus_if.bus_fromin}, 0);
        chk("arst_err", {31'b0, bus_if.err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_ready", {31'b0, bus_if.req_ready}, 1);

`ifdef CORE_BUS_TIMEOUT_EN
        // Load that is never acked: strobe for TMO cycles, then err + all-ones data
        push_txn(1'b0, 16'h0BAD, 16'h0000, 4);
        q_load.push_back(16'hFFFF);
        q_err.push_back(1);
        issue(1'b0, 16'h0BAD, 16'h0000);
        repeat (3) begin
            chk("tmo_rd_high", {31'b0, bus_if.bus_rd}, 1);
            @(negedge clk);
        end
        chk("tmo_rd_last", {31'b0, bus_if.bus_rd}, 1);
        @(negedge clk);
        chk("tmo_err", {31'b0, bus_if.err}, 1);
        chk("tmo_fromin", {31'b0, bus_if.bus_fromin}, 1);
        chk("tmo_datain", {16'b0, bus_if.bus_datain}, 32'h0000FFFF);
        @(negedge clk);
        chk("tmo_err_clear", {31'b0, bus_if.err}, 0);
        chk("tmo_ready", {31'b0, bus_if.req_ready}, 1);

        // Ack on the last allowed cycle wins over the timeout
        push_txn(1'b0, 16'h0C00, 16'h0000, 4);
        q_load.push_back(16'h1357);
        issue(1'b0, 16'h0C00, 16'h0000);
        repeat (3) @(negedge clk);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'h1357;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        chk("race_err", {31'b0, bus_if.err}, 0);
        chk("race_datain", {16'b0, bus_if.bus_datain}, 32'h00001357);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("txn_queue_empty", q_txn.size(), 0);
        chk("load_queue_empty", q_load.size(), 0);
        chk("err_queue_empty", q_err.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
